// File: rtl/inst_fetch_unit_if.sv
// inst_fetch_unit_if: instruction-bus, redirect and decode-side signals of the fetch unit.
interface inst_fetch_unit_if;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_adef;

    modport master (
        output inst_sram_req, inst_sram_addr, id_valid, id_pc, id_instr, id_adef,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  inst_sram_req, inst_sram_addr, id_valid, id_pc, id_instr, id_adef,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: sequential instruction fetch into an in-order buffer, with redirect flush
// and fetch-address-error injection for misaligned PCs.
module inst_fetch_unit #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h1c000000
) (
    input logic               aclk,
    input logic               aresetn,
    inst_fetch_unit_if.master bus
);
    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH      = (AW + 1)'(FIFO_DEPTH);
    localparam logic [31:0] ADEF_INSTR = 32'h03400000;

    typedef enum logic {RUN, HOLD} state_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc, fetch_pc_nxt, hold_pc, push_pc;
    logic [AW:0]   inflight, inflight_nxt, stale, stale_nxt, count, count_nxt, live;
    logic [AW-1:0] rd_ptr, wr_ptr, tag_rd, tag_wr;
    logic [31:0]   fifo_pc [FIFO_DEPTH];
    logic [31:0]   fifo_instr [FIFO_DEPTH];
    logic          fifo_adef [FIFO_DEPTH];
    logic [31:0]   tag_pc [FIFO_DEPTH];
    logic          adef_stop, adef_stop_nxt;
    logic          redirect, resp, accept, hold_acc, stall, misaligned;
    logic          push_data, push_adef, push, pop;

    assign redirect   = bus.redirect_valid;
    assign resp       = bus.inst_sram_data_ok;
    assign misaligned = fetch_pc[1:0] != 2'b00;
    assign live       = inflight - stale;

    // A request left pending by a redirect (HOLD) must stay up until accepted
    assign bus.inst_sram_req  = aresetn && (state == HOLD ||
                                (!adef_stop && !misaligned && inflight < DEPTH && count + live < DEPTH));
    assign bus.inst_sram_addr = fetch_pc;

    assign accept    = bus.inst_sram_req && bus.inst_sram_addr_ok;
    assign hold_acc  = state == HOLD && accept;
    assign stall     = redirect && bus.inst_sram_req && !bus.inst_sram_addr_ok;
    assign push_data = resp && stale == '0 && !redirect;
    assign push_adef = state == RUN && misaligned && !adef_stop && inflight == '0 && stale == '0 &&
                       count < DEPTH && !redirect;
    assign push      = push_data || push_adef;
    assign push_pc   = push_adef ? fetch_pc : tag_pc[tag_rd];

    assign bus.id_valid = count != '0;
    assign pop          = bus.id_valid && bus.id_ready;
    assign bus.id_pc    = bus.id_valid ? fifo_pc[rd_ptr] : '0;
    assign bus.id_instr = bus.id_valid ? fifo_instr[rd_ptr] : '0;
    assign bus.id_adef  = bus.id_valid && fifo_adef[rd_ptr];

    always_comb begin
        inflight_nxt  = inflight + (AW + 1)'(accept) - (AW + 1)'(resp);
        stale_nxt     = redirect ? inflight_nxt
                                 : stale + (AW + 1)'(hold_acc) - (AW + 1)'(resp && stale != '0);
        count_nxt     = redirect ? '0 : count + (AW + 1)'(push) - (AW + 1)'(pop);
        state_nxt     = stall ? HOLD : accept ? RUN : state;
        fetch_pc_nxt  = stall ? fetch_pc : redirect ? bus.redirect_pc : hold_acc ? hold_pc :
                        accept ? fetch_pc + 32'd4 : fetch_pc;
        adef_stop_nxt = redirect ? 1'b0 : push_adef ? 1'b1 : adef_stop;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= RUN;
            fetch_pc  <= RESET_PC;
            hold_pc   <= RESET_PC;
            inflight  <= '0;
            stale     <= '0;
            count     <= '0;
            adef_stop <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            tag_rd    <= '0;
            tag_wr    <= '0;
        end else begin
            state     <= state_nxt;
            fetch_pc  <= fetch_pc_nxt;
            inflight  <= inflight_nxt;
            stale     <= stale_nxt;
            count     <= count_nxt;
            adef_stop <= adef_stop_nxt;
            if (stall) hold_pc <= bus.redirect_pc;
            if (accept) tag_wr <= tag_wr + AW'(1);
            if (resp) tag_rd <= tag_rd + AW'(1);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= redirect ? wr_ptr : pop ? rd_ptr + AW'(1) : rd_ptr;
        end
    end

    always_ff @(posedge aclk) begin
        if (accept) tag_pc[tag_wr] <= fetch_pc;
        if (push) begin
            fifo_pc[wr_ptr]    <= push_pc;
            fifo_instr[wr_ptr] <= push_adef ? ADEF_INSTR : bus.inst_sram_rdata;
            fifo_adef[wr_ptr]  <= push_adef;
        end
    end
endmodule
